// File: rtl/serial_nbit_adder_pkg.sv
// Shared definitions for the digit-serial adder/subtractor.
// Contents:
//   ST_IDLE / ST_RUN / ST_DONE  FSM state encoding
//   clog2(n)                    counter width for n digit steps, never less than 1 bit
package serial_nbit_adder_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Bits needed to count 0..n-1. A single-digit operand still gets a 1-bit counter.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned w;
        w = 1;
        for (int unsigned i = 1; i < 32; i++) begin
            if ((32'd1 << i) < n) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/serial_nbit_adder_if.sv
// Operand/result handshake bundle for serial_nbit_adder.
// Signals:
//   start_valid/start_ready  operand handshake (requester -> adder)
//   a, b, sub, cin           operands and mode, sampled on the accepting edge
//   res_valid/res_ready      result handshake (adder -> consumer)
//   s, co, ovf               sum/difference, carry-out (1 = no borrow in sub), signed overflow
// Modports: master = requester/consumer side, slave = adder side.
interface serial_nbit_adder_if #(
    parameter int unsigned WIDTH = 8
) ();

    logic             start_valid;
    logic             start_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             cin;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] s;
    logic             co;
    logic             ovf;

    modport master (
        output start_valid, a, b, sub, cin, res_ready,
        input  start_ready, res_valid, s, co, ovf
    );

    modport slave (
        input  start_valid, a, b, sub, cin, res_ready,
        output start_ready, res_valid, s, co, ovf
    );

endinterface

// File: rtl/serial_digit_adder.sv
// Combinational DIGIT-bit ripple-carry adder used for one digit step.
// Ports:
//   i_x, i_y  digit operands
//   i_ci      carry into bit 0
//   o_sum     digit sum
//   o_co      carry out of the top bit
//   o_c_msb   carry into the top bit (for signed overflow)
module serial_digit_adder #(
    parameter int unsigned DIGIT = 2
) (
    input  logic [DIGIT-1:0] i_x,
    input  logic [DIGIT-1:0] i_y,
    input  logic             i_ci,
    output logic [DIGIT-1:0] o_sum,
    output logic             o_co,
    output logic             o_c_msb
);

    logic w_c;

    always_comb begin
        w_c     = i_ci;
        o_c_msb = 1'b0;
        o_sum   = '0;
        for (int i = 0; i < int'(DIGIT); i++) begin
            if (i == int'(DIGIT) - 1) begin
                o_c_msb = w_c;
            end
            o_sum[i] = i_x[i] ^ i_y[i] ^ w_c;
            w_c      = (i_x[i] & i_y[i]) | (w_c & (i_x[i] ^ i_y[i]));
        end
        o_co = w_c;
    end

endmodule

// File: rtl/serial_nbit_adder.sv
// Digit-serial WIDTH-bit adder/subtractor, DIGIT bits per clock, LSB digit first.
// WIDTH must be a multiple of DIGIT and at least 2; DIGIT at least 1.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    serial_nbit_adder_if.slave: operand handshake in, result handshake out
// Operation: accept in IDLE, NDIG = WIDTH/DIGIT RUN cycles, then present the
// result in DONE until res_ready. s/co/ovf hold their last value outside DONE.
module serial_nbit_adder
    import serial_nbit_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    serial_nbit_adder_if.slave     bus
);

    localparam int unsigned     NDIG = WIDTH / DIGIT;
    localparam int unsigned     CW   = clog2(NDIG);
    localparam logic [CW-1:0]   LAST = CW'(NDIG - 1);

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_s;
    logic             r_carry;
    logic             r_co;
    logic             r_ovf;
    logic [CW-1:0]    r_cnt;

    logic [DIGIT-1:0]       w_d;
    logic                   w_co;
    logic                   w_c_msb;
    logic [WIDTH+DIGIT-1:0] w_cat;
    logic [WIDTH-1:0]       w_acc_next;

    serial_digit_adder #(
        .DIGIT (DIGIT)
    ) u_digit (
        .i_x     (r_a[DIGIT-1:0]),
        .i_y     (r_b[DIGIT-1:0]),
        .i_ci    (r_carry),
        .o_sum   (w_d),
        .o_co    (w_co),
        .o_c_msb (w_c_msb)
    );

    // New digit enters from the MSB side; after NDIG steps the LSB digit sits at bit 0.
    // The concatenation avoids an empty slice when DIGIT == WIDTH.
    assign w_cat      = {w_d, r_acc};
    assign w_acc_next = w_cat[WIDTH+DIGIT-1:DIGIT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_s     <= '0;
            r_carry <= 1'b0;
            r_co    <= 1'b0;
            r_ovf   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.start_valid) begin
                        // Subtract as a + ~b + ~cin: invert B, and carry-in becomes cin ^ 1.
                        r_a     <= bus.a;
                        r_b     <= bus.sub ? ~bus.b : bus.b;
                        r_carry <= bus.cin ^ bus.sub;
                        r_cnt   <= '0;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_acc   <= w_acc_next;
                    r_a     <= r_a >> DIGIT;
                    r_b     <= r_b >> DIGIT;
                    r_carry <= w_co;
                    r_cnt   <= r_cnt + 1'b1;
                    if (r_cnt == LAST) begin
                        r_s     <= w_acc_next;
                        r_co    <= w_co;
                        r_ovf   <= w_co ^ w_c_msb;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (bus.res_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        // Not ready while reset is held, only once it is released.
        bus.start_ready = rst_n && (r_state == ST_IDLE);
        bus.res_valid   = (r_state == ST_DONE);
        bus.s           = r_s;
        bus.co          = r_co;
        bus.ovf         = r_ovf;
    end

endmodule

// File: tb/tb_serial_nbit_adder.sv
// Self-checking bench for serial_nbit_adder at (8,2), (8,1), (8,8) and (16,4).
module tb_serial_nbit_adder;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    serial_nbit_adder_if #(.WIDTH(8))  if0 ();
    serial_nbit_adder_if #(.WIDTH(8))  if1 ();
    serial_nbit_adder_if #(.WIDTH(8))  if2 ();
    serial_nbit_adder_if #(.WIDTH(16)) if3 ();

    serial_nbit_adder #(.WIDTH(8), .DIGIT(2)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
    serial_nbit_adder #(.WIDTH(8), .DIGIT(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
    serial_nbit_adder #(.WIDTH(8), .DIGIT(8)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));
    serial_nbit_adder #(.WIDTH(16), .DIGIT(4)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(if3.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int width_of(input int inst);
        return (inst == 3) ? 16 : 8;
    endfunction

    function automatic int ndig_of(input int inst);
        case (inst)
            0:       return 4;
            1:       return 8;
            2:       return 1;
            default: return 4;
        endcase
    endfunction

    task automatic set_in(input int inst, input logic sv, input logic [15:0] a, input logic [15:0] b,
                          input logic sub, input logic cin);
        case (inst)
            0: begin if0.start_valid = sv; if0.a = a[7:0]; if0.b = b[7:0]; if0.sub = sub; if0.cin = cin; end
            1: begin if1.start_valid = sv; if1.a = a[7:0]; if1.b = b[7:0]; if1.sub = sub; if1.cin = cin; end
            2: begin if2.start_valid = sv; if2.a = a[7:0]; if2.b = b[7:0]; if2.sub = sub; if2.cin = cin; end
            default: begin if3.start_valid = sv; if3.a = a; if3.b = b; if3.sub = sub; if3.cin = cin; end
        endcase
    endtask

    task automatic set_rr(input int inst, input logic v);
        case (inst)
            0: if0.res_ready = v;
            1: if1.res_ready = v;
            2: if2.res_ready = v;
            default: if3.res_ready = v;
        endcase
    endtask

    task automatic sample(input int inst, output logic sr, output logic rv, output logic [15:0] s,
                          output logic co, output logic ovf);
        case (inst)
            0: begin sr = if0.start_ready; rv = if0.res_valid; s = {8'h00, if0.s}; co = if0.co; ovf = if0.ovf; end
            1: begin sr = if1.start_ready; rv = if1.res_valid; s = {8'h00, if1.s}; co = if1.co; ovf = if1.ovf; end
            2: begin sr = if2.start_ready; rv = if2.res_valid; s = {8'h00, if2.s}; co = if2.co; ovf = if2.ovf; end
            default: begin sr = if3.start_ready; rv = if3.res_valid; s = if3.s; co = if3.co; ovf = if3.ovf; end
        endcase
    endtask

    // Reference: integer arithmetic on unsigned and signed views of the operands.
    task automatic model(input int w, input logic [15:0] a, input logic [15:0] b, input logic sub,
                         input logic cin, output logic [15:0] s, output logic co, output logic ovf);
        longint m, half, ua, ub, sa, sb, r, sr;
        m    = longint'(1) << w;
        half = m / 2;
        ua   = longint'(a) % m;
        ub   = longint'(b) % m;
        sa   = (ua >= half) ? ua - m : ua;
        sb   = (ub >= half) ? ub - m : ub;
        if (!sub) begin
            r  = ua + ub + longint'(cin);
            co = (r >= m);
            sr = sa + sb + longint'(cin);
        end else begin
            r  = ua - ub - longint'(cin);
            co = (r >= 0);
            sr = sa - sb - longint'(cin);
        end
        ovf = (sr < -half) || (sr >= half);
        s   = 16'(((r % m) + m) % m);
    endtask

    // Issues one operation, waits for the result, consumes it. Starts and ends on a negedge.
    // lat = edges from the accepting edge to res_valid, or -1 if a bound expired.
    task automatic run_txn(input int inst, input logic [15:0] a, input logic [15:0] b, input logic sub,
                           input logic cin, output logic [15:0] s, output logic co, output logic ovf,
                           output int lat);
        logic sr, rv, c, o;
        logic [15:0] ss;
        int n;
        n = 0;
        sample(inst, sr, rv, ss, c, o);
        while (!sr && n < 50) begin
            @(negedge clk);
            n++;
            sample(inst, sr, rv, ss, c, o);
        end
        set_in(inst, 1'b1, a, b, sub, cin);
        set_rr(inst, 1'b0);
        @(negedge clk);
        set_in(inst, 1'b0, a, b, sub, cin);
        lat = 0;
        sample(inst, sr, rv, ss, c, o);
        while (!rv && lat < 100) begin
            @(negedge clk);
            lat++;
            sample(inst, sr, rv, ss, c, o);
        end
        if (!rv || n >= 50) lat = -1;
        s   = ss;
        co  = c;
        ovf = o;
        set_rr(inst, 1'b1);
        @(negedge clk);
        set_rr(inst, 1'b0);
    endtask

    task automatic test_reset();
        logic sr, rv, c, o;
        logic [15:0] s;
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_in(i, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
            set_rr(i, 1'b0);
        end
        @(negedge clk);
        @(negedge clk);
        sample(0, sr, rv, s, c, o);
        checks++; if (rv !== 1'b0) begin errors++; $display("FAIL reset_res_valid: got %b want 0", rv); end
        checks++; if (s !== 16'h0) begin errors++; $display("FAIL reset_s: got %h want 00", s); end
        checks++; if (c !== 1'b0) begin errors++; $display("FAIL reset_co: got %b want 0", c); end
        checks++; if (o !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", o); end
        rst_n = 1'b1;
        #1;
        sample(0, sr, rv, s, c, o);
        checks++; if (sr !== 1'b1) begin errors++; $display("FAIL reset_start_ready: got %b want 1", sr); end
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [7:0] da[5]  = '{8'h5A, 8'hFF, 8'hFF, 8'h10, 8'h80};
        logic [7:0] db[5]  = '{8'h3C, 8'h01, 8'h01, 8'h20, 8'h01};
        logic       dsb[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic       dci[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [7:0] ds[5]  = '{8'h96, 8'h00, 8'h01, 8'hF0, 8'h7F};
        logic       dco[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        logic       dov[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [15:0] s;
        logic c, o, sr, rv;
        int lat;
        for (int i = 0; i < 5; i++) begin
            run_txn(0, {8'h00, da[i]}, {8'h00, db[i]}, dsb[i], dci[i], s, c, o, lat);
            checks++; if (s !== {8'h00, ds[i]}) begin errors++; $display("FAIL directed%0d_s: got %h want %h", i, s, ds[i]); end
            checks++; if (c !== dco[i]) begin errors++; $display("FAIL directed%0d_co: got %b want %b", i, c, dco[i]); end
            checks++; if (o !== dov[i]) begin errors++; $display("FAIL directed%0d_ovf: got %b want %b", i, o, dov[i]); end
            checks++; if (lat !== 4) begin errors++; $display("FAIL directed%0d_latency: got %0d want 4", i, lat); end
            sample(0, sr, rv, s, c, o);
            checks++; if (rv !== 1'b0 || sr !== 1'b1) begin
                errors++; $display("FAIL directed%0d_release: got valid=%b ready=%b want 0/1", i, rv, sr);
            end
        end
    endtask

    task automatic test_backpressure();
        logic sr, rv, c, o;
        logic [15:0] s;
        int n;
        set_rr(0, 1'b0);
        set_in(0, 1'b1, 16'h005A, 16'h003C, 1'b0, 1'b0);
        @(negedge clk);
        set_in(0, 1'b0, 16'h005A, 16'h003C, 1'b0, 1'b0);
        n = 0;
        sample(0, sr, rv, s, c, o);
        while (!rv && n < 20) begin
            @(negedge clk);
            n++;
            sample(0, sr, rv, s, c, o);
        end
        checks++; if (rv !== 1'b1) begin errors++; $display("FAIL bp_reach_done: got %b want 1", rv); end
        for (int i = 0; i < 10; i++) begin
            set_in(0, 1'(i % 2), 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
            @(negedge clk);
            sample(0, sr, rv, s, c, o);
            checks++; if (rv !== 1'b1 || sr !== 1'b0) begin
                errors++; $display("FAIL bp_hold%0d_handshake: got valid=%b ready=%b want 1/0", i, rv, sr);
            end
            checks++; if (s !== 16'h0096 || c !== 1'b0 || o !== 1'b1) begin
                errors++; $display("FAIL bp_hold%0d_result: got s=%h co=%b ovf=%b want 96/0/1", i, s, c, o);
            end
        end
        set_in(0, 1'b1, 16'h0011, 16'h0022, 1'b0, 1'b0);
        set_rr(0, 1'b1);
        @(negedge clk);
        set_in(0, 1'b0, 16'h0011, 16'h0022, 1'b0, 1'b0);
        set_rr(0, 1'b0);
        sample(0, sr, rv, s, c, o);
        checks++; if (rv !== 1'b0 || sr !== 1'b1) begin
            errors++; $display("FAIL bp_release: got valid=%b ready=%b want 0/1", rv, sr);
        end
        checks++; if (s !== 16'h0096) begin errors++; $display("FAIL bp_s_kept: got %h want 96", s); end
        @(negedge clk);
        sample(0, sr, rv, s, c, o);
        checks++; if (sr !== 1'b1) begin errors++; $display("FAIL bp_no_capture: got ready=%b want 1", sr); end
    endtask

    task automatic test_reset_mid();
        logic sr, rv, c, o;
        logic [15:0] s;
        int lat;
        set_rr(0, 1'b0);
        set_in(0, 1'b1, 16'h00C3, 16'h005A, 1'b0, 1'b1);
        @(negedge clk);
        set_in(0, 1'b0, 16'h00C3, 16'h005A, 1'b0, 1'b1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        sample(0, sr, rv, s, c, o);
        checks++; if (rv !== 1'b0 || s !== 16'h0 || c !== 1'b0 || o !== 1'b0) begin
            errors++; $display("FAIL midreset_outputs: got valid=%b s=%h co=%b ovf=%b want 0/00/0/0", rv, s, c, o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_txn(0, 16'h0001, 16'h0001, 1'b0, 1'b0, s, c, o, lat);
        checks++; if (s !== 16'h0002 || c !== 1'b0 || o !== 1'b0) begin
            errors++; $display("FAIL midreset_next: got s=%h co=%b ovf=%b want 02/0/0", s, c, o);
        end
        checks++; if (lat !== 4) begin errors++; $display("FAIL midreset_latency: got %0d want 4", lat); end
    endtask

    task automatic test_random(input int inst, input int count);
        logic [15:0] a, b, s, es, mask;
        logic sub, cin, c, o, ec, eo;
        int lat, w;
        w    = width_of(inst);
        mask = (w == 16) ? 16'hFFFF : 16'h00FF;
        for (int i = 0; i < count; i++) begin
            a   = 16'($urandom) & mask;
            b   = 16'($urandom) & mask;
            sub = 1'($urandom);
            cin = 1'($urandom);
            model(w, a, b, sub, cin, es, ec, eo);
            run_txn(inst, a, b, sub, cin, s, c, o, lat);
            checks++; if (s !== es) begin
                errors++; $display("FAIL rand_i%0d_s (a=%h b=%h sub=%b cin=%b): got %h want %h", inst, a, b, sub, cin, s, es);
            end
            checks++; if (c !== ec) begin
                errors++; $display("FAIL rand_i%0d_co (a=%h b=%h sub=%b cin=%b): got %b want %b", inst, a, b, sub, cin, c, ec);
            end
            checks++; if (o !== eo) begin
                errors++; $display("FAIL rand_i%0d_ovf (a=%h b=%h sub=%b cin=%b): got %b want %b", inst, a, b, sub, cin, o, eo);
            end
            checks++; if (lat !== ndig_of(inst)) begin
                errors++; $display("FAIL rand_i%0d_latency: got %0d want %0d", inst, lat, ndig_of(inst));
            end
        end
    endtask

    task automatic test_sweep();
        for (int inst = 1; inst < 4; inst++) begin
            test_random(inst, 8);
        end
    endtask

    // start_valid and res_ready held high: operations issue every NDIG+2 cycles.
    task automatic test_back_to_back();
        logic [15:0] qs[$];
        logic        qc[$];
        logic        qo[$];
        int          acc[$];
        logic [15:0] s, a, b, es;
        logic sr, rv, c, o, sub, cin, ec, eo;
        int got, n;
        got = 0;
        set_rr(0, 1'b1);
        for (int cyc = 0; cyc < 80 && got < 4; cyc++) begin
            sample(0, sr, rv, s, c, o);
            if (rv) begin
                checks++;
                if (qs.size() == 0) begin
                    errors++; $display("FAIL b2b_unexpected_result: got s=%h want none", s);
                end else if (s !== qs[0] || c !== qc[0] || o !== qo[0]) begin
                    errors++;
                    $display("FAIL b2b_result%0d: got s=%h co=%b ovf=%b want %h/%b/%b", got, s, c, o, qs[0], qc[0], qo[0]);
                end
                if (qs.size() != 0) begin
                    void'(qs.pop_front()); void'(qc.pop_front()); void'(qo.pop_front());
                end
                got++;
            end
            if (sr) begin
                a   = 16'($urandom) & 16'h00FF;
                b   = 16'($urandom) & 16'h00FF;
                sub = 1'($urandom);
                cin = 1'($urandom);
                model(8, a, b, sub, cin, es, ec, eo);
                qs.push_back(es); qc.push_back(ec); qo.push_back(eo);
                acc.push_back(cyc);
                set_in(0, 1'b1, a, b, sub, cin);
            end
            @(negedge clk);
        end
        checks++; if (got !== 4) begin errors++; $display("FAIL b2b_results: got %0d want 4", got); end
        for (int i = 1; i < 4; i++) begin
            checks++;
            if (acc.size() <= i) begin
                errors++; $display("FAIL b2b_interval%0d: got none want 6", i);
            end else if (acc[i] - acc[i-1] != 6) begin
                errors++; $display("FAIL b2b_interval%0d: got %0d want 6", i, acc[i] - acc[i-1]);
            end
        end
        set_in(0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        n = 0;
        sample(0, sr, rv, s, c, o);
        while (!(sr && !rv) && n < 20) begin
            @(negedge clk);
            n++;
            sample(0, sr, rv, s, c, o);
        end
        set_rr(0, 1'b0);
        checks++; if (sr !== 1'b1) begin errors++; $display("FAIL b2b_drain: got ready=%b want 1", sr); end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid();
        test_random(0, 12);
        test_sweep();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
